// File: rtl/btb_access_controller.sv
// BTB RAM access controller: arbitrates a single-port BTB RAM between fetch lookups and
// queued execute updates, forwards pending updates to lookups, and runs invalidate sweeps.
module btb_access_controller #(
  parameter int ENTRY_NUM          = 1024,
  parameter int TAG_W              = 4,
  parameter int CONTENT_W          = 13,
  parameter int UPDATE_QUEUE_DEPTH = 2,
  localparam int IDX_W = $clog2(ENTRY_NUM),
  localparam int RAM_W = 1 + TAG_W + CONTENT_W
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             lookupReq,
  input  logic [31:0]      lookupPC,
  output logic             lookupReady,
  output logic             lookupRespValid,
  output logic             lookupHit,
  output logic [31:0]      lookupTarget,
  input  logic             updateReq,
  input  logic [31:0]      updatePC,
  input  logic [31:0]      updateTarget,
  output logic             updateReady,
  input  logic             invalidateAll,
  output logic             ramEn,
  output logic             ramWe,
  output logic [IDX_W-1:0] ramAddr,
  output logic [RAM_W-1:0] ramWData,
  input  logic [RAM_W-1:0] ramRData
);

  localparam int PTR_W  = (UPDATE_QUEUE_DEPTH > 1) ? $clog2(UPDATE_QUEUE_DEPTH) : 1;
  localparam int CNT_W  = $clog2(UPDATE_QUEUE_DEPTH + 1);
  localparam int HI_W   = 30 - CONTENT_W;
  localparam int TAG_LO = IDX_W + 2;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                 state_reg, state_next;
  logic [IDX_W-1:0]       sweep_idx_reg, sweep_idx_next;

  logic [IDX_W-1:0]       q_idx_reg     [UPDATE_QUEUE_DEPTH];
  logic [TAG_W-1:0]       q_tag_reg     [UPDATE_QUEUE_DEPTH];
  logic [CONTENT_W-1:0]   q_content_reg [UPDATE_QUEUE_DEPTH];
  logic [UPDATE_QUEUE_DEPTH-1:0] q_vld_reg;
  logic [PTR_W-1:0]       head_reg, tail_reg;
  logic [CNT_W-1:0]       count_reg;

  logic                   resp_valid_reg, kill_reg, fwd_hit_reg;
  logic [CONTENT_W-1:0]   fwd_content_reg;
  logic [HI_W-1:0]        resp_hi_reg;
  logic [TAG_W-1:0]       resp_tag_reg;

  logic                   is_run, q_full, q_empty, flush, enq, deq, lookup_accept;
  logic                   fwd_hit_next;
  logic [CONTENT_W-1:0]   fwd_content_next;
  logic [UPDATE_QUEUE_DEPTH-1:0] slot_match;
  int                     fwd_slot;
  logic                   ram_hit, resp_hit;
  logic [CONTENT_W-1:0]   resp_content;
  logic                   unused_bits;

  wire [IDX_W-1:0]     lk_idx     = lookupPC[IDX_W+1:2];
  wire [TAG_W-1:0]     lk_tag     = lookupPC[TAG_LO+TAG_W-1:TAG_LO];
  wire [IDX_W-1:0]     up_idx     = updatePC[IDX_W+1:2];
  wire [TAG_W-1:0]     up_tag     = updatePC[TAG_LO+TAG_W-1:TAG_LO];
  wire [CONTENT_W-1:0] up_content = updateTarget[CONTENT_W+1:2];

  assign unused_bits = ^{lookupPC[1:0], updatePC[31:TAG_LO+TAG_W], updatePC[1:0],
                         updateTarget[31:CONTENT_W+2], updateTarget[1:0]};

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(UPDATE_QUEUE_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign is_run  = (state_reg == ST_RUN);
  assign q_full  = (count_reg == CNT_W'(UPDATE_QUEUE_DEPTH));
  assign q_empty = (count_reg == '0);
  assign flush   = is_run && invalidateAll;
  assign enq     = updateReq && updateReady && !invalidateAll;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_reg     <= ST_INIT;
      sweep_idx_reg <= '0;
    end else begin
      state_reg     <= state_next;
      sweep_idx_reg <= sweep_idx_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    sweep_idx_next = sweep_idx_reg;
    if (state_reg == ST_INIT) begin
      if (sweep_idx_reg == IDX_W'(ENTRY_NUM - 1)) begin
        state_next     = ST_RUN;
        sweep_idx_next = '0;
      end else begin
        sweep_idx_next = sweep_idx_reg + 1'b1;
      end
    end else if (invalidateAll) begin
      state_next     = ST_INIT;
      sweep_idx_next = '0;
    end
  end

  // Full queue beats lookups so updates cannot starve; otherwise lookups win the port.
  always_comb begin
    ramEn         = 1'b0;
    ramWe         = 1'b0;
    ramAddr       = '0;
    ramWData      = '0;
    lookup_accept = 1'b0;
    deq           = 1'b0;
    lookupReady   = is_run && !q_full;
    updateReady   = is_run && !q_full;
    if (!rstN) begin
      ramEn = 1'b0;
    end else if (state_reg == ST_INIT) begin
      ramEn   = 1'b1;
      ramWe   = 1'b1;
      ramAddr = sweep_idx_reg;
    end else if (q_full || (q_empty == 1'b0 && !lookupReq)) begin
      ramEn    = 1'b1;
      ramWe    = 1'b1;
      ramAddr  = q_idx_reg[head_reg];
      ramWData = {1'b1, q_tag_reg[head_reg], q_content_reg[head_reg]};
      deq      = 1'b1;
    end else if (lookupReq) begin
      ramEn         = 1'b1;
      ramAddr       = lk_idx;
      lookup_accept = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      q_vld_reg <= '0;
    end else if (flush) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      q_vld_reg <= '0;
    end else begin
      if (deq) begin
        q_vld_reg[head_reg] <= 1'b0;
        head_reg            <= ptr_inc(head_reg);
      end
      if (enq) begin
        q_vld_reg[tail_reg] <= 1'b1;
        tail_reg            <= ptr_inc(tail_reg);
      end
      count_reg <= count_reg + CNT_W'(enq) - CNT_W'(deq);
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      q_idx_reg[tail_reg]     <= up_idx;
      q_tag_reg[tail_reg]     <= up_tag;
      q_content_reg[tail_reg] <= up_content;
    end
  end

  for (genvar gi = 0; gi < UPDATE_QUEUE_DEPTH; gi++) begin : g_match
    assign slot_match[gi] = q_vld_reg[gi] && (q_idx_reg[gi] == lk_idx) && (q_tag_reg[gi] == lk_tag);
  end

  // Walk oldest to newest so the youngest matching update wins; a same-cycle enqueue is youngest.
  always_comb begin
    fwd_hit_next     = 1'b0;
    fwd_content_next = '0;
    fwd_slot         = 0;
    for (int k = 0; k < UPDATE_QUEUE_DEPTH; k++) begin
      fwd_slot = (int'(head_reg) + k) % UPDATE_QUEUE_DEPTH;
      if (slot_match[fwd_slot]) begin
        fwd_hit_next     = 1'b1;
        fwd_content_next = q_content_reg[fwd_slot];
      end
    end
    if (enq && (up_idx == lk_idx) && (up_tag == lk_tag)) begin
      fwd_hit_next     = 1'b1;
      fwd_content_next = up_content;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      resp_valid_reg  <= 1'b0;
      kill_reg        <= 1'b0;
      fwd_hit_reg     <= 1'b0;
      fwd_content_reg <= '0;
      resp_hi_reg     <= '0;
      resp_tag_reg    <= '0;
    end else begin
      resp_valid_reg <= lookup_accept;
      kill_reg       <= lookup_accept && flush;
      if (lookup_accept) begin
        fwd_hit_reg     <= fwd_hit_next;
        fwd_content_reg <= fwd_content_next;
        resp_hi_reg     <= lookupPC[31:CONTENT_W+2];
        resp_tag_reg    <= lk_tag;
      end
    end
  end

  assign ram_hit      = ramRData[RAM_W-1] && (ramRData[RAM_W-2 -: TAG_W] == resp_tag_reg);
  assign resp_hit     = resp_valid_reg && !kill_reg && (fwd_hit_reg || ram_hit);
  assign resp_content = fwd_hit_reg ? fwd_content_reg : ramRData[CONTENT_W-1:0];

  assign lookupRespValid = resp_valid_reg;
  assign lookupHit       = resp_hit;
  assign lookupTarget    = resp_hit ? {resp_hi_reg, resp_content, 2'b00} : '0;

endmodule

// File: tb/tb_btb_access_controller.sv
// Self-checking bench for btb_access_controller: directed scenarios plus randomized traffic
// compared against an architectural direct-mapped BTB model with a queue-occupancy counter.
module tb_btb_access_controller;

  localparam int ENTRY_NUM = 1024;
  localparam int DEPTH     = 2;
  localparam int RAM_W     = 18;

  logic             clk;
  logic             rstN = 1'b1;
  logic             lookupReq = 1'b0;
  logic [31:0]      lookupPC = '0;
  logic             lookupReady, lookupRespValid, lookupHit;
  logic [31:0]      lookupTarget;
  logic             updateReq = 1'b0;
  logic [31:0]      updatePC = '0;
  logic [31:0]      updateTarget = '0;
  logic             updateReady;
  logic             invalidateAll = 1'b0;
  logic             ramEn, ramWe;
  logic [9:0]       ramAddr;
  logic [RAM_W-1:0] ramWData;
  logic [RAM_W-1:0] ramRData;

  btb_access_controller dut (
    .clk(clk), .rstN(rstN),
    .lookupReq(lookupReq), .lookupPC(lookupPC), .lookupReady(lookupReady),
    .lookupRespValid(lookupRespValid), .lookupHit(lookupHit), .lookupTarget(lookupTarget),
    .updateReq(updateReq), .updatePC(updatePC), .updateTarget(updateTarget),
    .updateReady(updateReady), .invalidateAll(invalidateAll),
    .ramEn(ramEn), .ramWe(ramWe), .ramAddr(ramAddr), .ramWData(ramWData), .ramRData(ramRData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [RAM_W-1:0] mem [ENTRY_NUM];
  always @(posedge clk) begin
    if (ramEn) begin
      if (ramWe) mem[ramAddr] <= ramWData;
      else       ramRData     <= mem[ramAddr];
    end
  end

  // Architectural model: the table as fetch should see it, plus queue occupancy.
  int          checks = 0;
  int          errors = 0;
  int          init_left;
  int          qcount;
  bit          g_vld     [ENTRY_NUM];
  logic [3:0]  g_tag     [ENTRY_NUM];
  logic [12:0] g_content [ENTRY_NUM];
  bit          resp_pend, resp_hit;
  logic [31:0] resp_tgt;
  bit          s_run, s_lacc, s_uacc, s_flush, s_deq;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < ENTRY_NUM; i++) g_vld[i] = 1'b0;
    qcount    = 0;
    resp_pend = 1'b0;
    init_left = ENTRY_NUM;
  endtask

  task automatic do_reset();
    lookupReq = 1'b0; updateReq = 1'b0; invalidateAll = 1'b0;
    #1 rstN = 1'b0;
    #2;
    chk("rst_lookupReady", {31'b0, lookupReady}, 0);
    chk("rst_updateReady", {31'b0, updateReady}, 0);
    chk("rst_respValid", {31'b0, lookupRespValid}, 0);
    chk("rst_hit", {31'b0, lookupHit}, 0);
    chk("rst_target", lookupTarget, 0);
    chk("rst_ramEn", {31'b0, ramEn}, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rstN = 1'b1;
    clear_model();
  endtask

  task automatic tick_check();
    @(negedge clk);
    s_run = (init_left == 0);
    chk("respValid", {31'b0, lookupRespValid}, {31'b0, resp_pend});
    if (resp_pend) begin
      chk("resp_hit", {31'b0, lookupHit}, {31'b0, resp_hit});
      chk("resp_target", lookupTarget, resp_tgt);
    end
    if (!s_run) begin
      chk("init_lookupReady", {31'b0, lookupReady}, 0);
      chk("init_updateReady", {31'b0, updateReady}, 0);
      chk("init_ramEn", {31'b0, ramEn}, 1);
      chk("init_ramWe", {31'b0, ramWe}, 1);
      chk("init_ramAddr", {22'b0, ramAddr}, ENTRY_NUM - init_left);
      chk("init_ramWData", {14'b0, ramWData}, 0);
      s_lacc = 1'b0; s_uacc = 1'b0; s_flush = 1'b0; s_deq = 1'b0;
    end else begin
      chk("lookupReady", {31'b0, lookupReady}, {31'b0, qcount < DEPTH});
      chk("updateReady", {31'b0, updateReady}, {31'b0, qcount < DEPTH});
      s_lacc  = lookupReq && (qcount < DEPTH);
      s_uacc  = updateReq && (qcount < DEPTH) && !invalidateAll;
      s_flush = invalidateAll;
      s_deq   = (qcount > 0) && ((qcount == DEPTH) || !lookupReq);
      chk("ramEn", {31'b0, ramEn}, {31'b0, s_lacc || s_deq});
      if (s_lacc || s_deq) chk("ramWe", {31'b0, ramWe}, {31'b0, s_deq});
      if (s_lacc) chk("ramAddr_rd", {22'b0, ramAddr}, {22'b0, lookupPC[11:2]});
      if (s_deq) chk("ramWData_valid", {31'b0, ramWData[17]}, 1);
    end
  endtask

  task automatic tick_commit();
    logic [9:0] idx;
    @(posedge clk);
    #1;
    if (!s_run) begin
      init_left--;
    end else begin
      if (s_uacc) begin
        idx            = updatePC[11:2];
        g_vld[idx]     = 1'b1;
        g_tag[idx]     = updatePC[15:12];
        g_content[idx] = updateTarget[14:2];
      end
      if (s_lacc) begin
        idx      = lookupPC[11:2];
        resp_hit = !s_flush && g_vld[idx] && (g_tag[idx] == lookupPC[15:12]);
        resp_tgt = resp_hit ? {lookupPC[31:15], g_content[idx], 2'b00} : 32'h0;
      end
      if (s_flush) begin
        for (int i = 0; i < ENTRY_NUM; i++) g_vld[i] = 1'b0;
        qcount    = 0;
        init_left = ENTRY_NUM;
      end else begin
        qcount = qcount + int'(s_uacc) - int'(s_deq);
      end
    end
    resp_pend = s_lacc;
  endtask

  task automatic tick();
    tick_check();
    tick_commit();
  endtask

  task automatic idle();
    lookupReq = 1'b0; updateReq = 1'b0; invalidateAll = 1'b0;
  endtask

  logic [9:0] idx_pool [6];
  logic [3:0] tag_pool [6];
  int         k, k2;
  logic [3:0] tg;

  initial begin
    for (int i = 0; i < 6; i++) begin
      idx_pool[i] = 10'(i * 97 + 5);
      tag_pool[i] = 4'(i + 3);
    end

    // Reset and initial sweep; requests and invalidates during INIT must be ignored.
    do_reset();
    lookupReq = 1'b1; lookupPC = 32'h0000_1004;
    updateReq = 1'b1; updatePC = 32'h0000_1004; updateTarget = 32'h0000_7000;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      invalidateAll = (i == 700);
      tick();
    end
    idle();
    tick_check();
    chk("t1_ready_after_sweep", {31'b0, lookupReady}, 1);
    tick_commit();

    // Update with the port idle drains straight to RAM next cycle.
    updateReq = 1'b1; updatePC = 32'h0000_1004; updateTarget = 32'h0000_2000;
    tick();
    idle();
    tick_check();
    chk("t2_wr_we", {31'b0, ramWe}, 1);
    chk("t2_wr_addr", {22'b0, ramAddr}, 1);
    chk("t2_wr_data", {14'b0, ramWData}, 32'h0002_2800);
    tick_commit();
    lookupReq = 1'b1; lookupPC = 32'h8000_1004;
    tick();
    idle();
    tick_check();
    chk("t2_hit", {31'b0, lookupHit}, 1);
    chk("t2_target", lookupTarget, 32'h8000_2000);
    tick_commit();

    // Same index, different tag misses.
    lookupReq = 1'b1; lookupPC = 32'h0000_2004;
    tick();
    idle();
    tick_check();
    chk("t3_valid", {31'b0, lookupRespValid}, 1);
    chk("t3_hit", {31'b0, lookupHit}, 0);
    chk("t3_target", lookupTarget, 0);
    tick_commit();

    // Forwarding under continuous lookups, then a full queue stalls lookups one cycle.
    lookupReq = 1'b1; lookupPC = 32'h0000_1004;
    updateReq = 1'b1; updatePC = 32'h0000_1004; updateTarget = 32'h0000_3000;
    tick();
    updatePC = 32'h0000_1008; updateTarget = 32'h0000_4000;
    tick_check();
    chk("t4_fwd_hit", {31'b0, lookupHit}, 1);
    chk("t4_fwd_target", lookupTarget, 32'h0000_3000);
    tick_commit();
    updateReq = 1'b0;
    tick_check();
    chk("t4_full_stall", {31'b0, lookupReady}, 0);
    tick_commit();
    tick_check();
    chk("t4_stall_released", {31'b0, lookupReady}, 1);
    tick_commit();
    tick();

    // Invalidate with a queued update, an offered update and a same-cycle lookup.
    invalidateAll = 1'b1;
    updateReq = 1'b1; updatePC = 32'h0000_100C; updateTarget = 32'h0000_5000;
    tick();
    idle();
    tick_check();
    chk("t5_valid", {31'b0, lookupRespValid}, 1);
    chk("t5_hit_killed", {31'b0, lookupHit}, 0);
    tick_commit();
    while (init_left > 0) tick();
    tick_check();
    chk("t5_queue_flushed", {31'b0, ramEn}, 0);
    tick_commit();
    lookupReq = 1'b1; lookupPC = 32'h0000_1004;
    tick();
    idle();
    tick_check();
    chk("t5_miss_after_sweep", {31'b0, lookupHit}, 0);
    tick_commit();

    // Randomized traffic: each pooled index only ever holds one tag.
    for (int n = 0; n < 600; n++) begin
      k  = $urandom_range(0, 5);
      k2 = $urandom_range(0, 5);
      tg = tag_pool[k];
      if ($urandom_range(0, 3) == 0) tg = tg + 4'd1;
      lookupReq    = ($urandom_range(0, 9) < 6);
      lookupPC     = {16'($urandom), tg, idx_pool[k], 2'b00};
      updateReq    = ($urandom_range(0, 9) < 4);
      updatePC     = {16'($urandom), tag_pool[k2], idx_pool[k2], 2'b00};
      updateTarget = $urandom;
      tick();
    end
    idle();
    tick();

    // Reset in the middle of a sweep restarts it from zero.
    do_reset();
    for (int i = 0; i < 500; i++) tick();
    do_reset();
    while (init_left > 0) tick();
    tick_check();
    chk("t6_ready_after_restart", {31'b0, lookupReady}, 1);
    tick_commit();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
